butterfly_pipe: RTL
===================

// Module: butterfly_pipe
// PURPOSE
//  Pipelined, parametrised radix-2 DIT butterfly for the FFT datapath: C1 = A + B*W, C2 = A - B*W.
//  Operands are packed complex words {re, im}, each half two's complement.
//  Adds a twiddle multiply, a bypass mode, per-sample scaling, saturation and valid/ready flow control.
//  Sits between the sample buffer and the FFT stage controller.
// PARAMETERS
//  DW  12  data width per real/imag half (packed words are 2*DW)
//  TW  12  twiddle width per half, Q1.(TW-1) fixed point (0x800 = -1.0 when TW=12)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      input sample valid
//  in_ready   out  1      block can accept a sample this cycle
//  A          in   2*DW   {Ar, Ai}
//  B          in   2*DW   {Br, Bi}
//  Wt         in   2*TW   twiddle {Wr, Wi}
//  bypass     in   1      1: P = B (no multiply); 0: P = B*Wt
//  scale      in   1      1: halve outputs with rounding
//  out_valid  out  1      C1/C2 valid
//  out_ready  in   1      downstream accepts C1/C2
//  C1         out  2*DW   {C1r, C1i} = sat(scl(A + P))
//  C2         out  2*DW   {C2r, C2i} = sat(scl(A - P))
//  ovf        out  1      sticky saturation flag
//  ovf_clr    in   1      synchronous clear of ovf (set wins if both occur in the same cycle)
// BEHAVIOUR
//  Reset: every pipeline register, out_valid, C1, C2 and ovf go to 0 immediately and asynchronously.
//    In-flight samples are discarded. in_ready = 1 once rst deasserts.
//  Transfer rules: an input transfers when in_valid & in_ready; an output transfers when out_valid & out_ready.
//    A, B, Wt, bypass and scale are sampled together on the input transfer and travel with the sample.
//  Pipeline: 3 stages, global enable en = ~out_valid | out_ready. in_ready = en.
//    When en=0, all stages hold and C1/C2/out_valid stay stable. No bubbles are collapsed.
//    Latency is exactly 3 cycles with out_ready=1. Throughput is 1 sample/cycle.
//    Each stage carries a valid bit; an empty stage never asserts out_valid.
//  S1: register the four products Br*Wr, Bi*Wi, Br*Wi and Bi*Wr (each DW+TW bits). Also register A and B.
//  S2: Pr = Br*Wr - Bi*Wi and Pi = Br*Wi + Bi*Wr (DW+TW+1 bits).
//    Round: add 2^(TW-2), then arithmetic shift right by TW-1, giving DW+2 bits.
//    If bypass: P = sign-extended B, giving DW+2 bits.
//  S3: S = A + P and D = A - P, both sign-extended to DW+3 bits.
//    If scale: x = (x + 1) >>> 1 (round half up).
//    Then saturate each half to [-2^(DW-1), 2^(DW-1)-1].
//    Any clipped half sets ovf at the S3 register update.
//  ovf stays set until ovf_clr or rst.
//  Twiddle -1.0 (Wr = -2^(TW-1)) is legal; the resulting overflow is absorbed by saturation.
//  A stalled sample never sets ovf twice (ovf updates only when en=1).
// TESTING
//  bypass=1, scale=0, A=0x064032, B=0x00A005 -> 3 cycles later C1=0x06E037, C2=0x05A02D.
//  bypass=0, Wt=0x800000 (-1.0), same A and B -> C1=0x05A02D, C2=0x06E037 (rounding is exact).
//  bypass=1, A=0x7FF000, B=0x001000, scale=0 -> C1=0x7FF000, C2=0x7FE000, ovf=1.
//    Repeat with scale=1 -> C1=0x400000, C2=0x3FF000.
//    Then pulse ovf_clr -> ovf=0.
//  Stream 8 samples with out_ready held low from cycle 2 for 5 cycles:
//    in_ready drops, C1/C2 stay stable, and all 8 results emerge in order with no loss or duplication.
//  Assert rst for 1 cycle with 3 samples in flight:
//    out_valid=0, C1=C2=0 and ovf=0 at once; no stale output appears afterwards.
//  1024 random vectors at full rate, both modes and both scale settings:
//    outputs match a bit-exact reference model, and error count = 0.

Source files
------------

// File: rtl/butterfly_pipe.sv
// Radix-2 DIT butterfly, 3-stage pipeline: C1 = A + B*W, C2 = A - B*W.
// Twiddle bypass, rounding halve, per-half saturation and sticky overflow.
module butterfly_pipe #(
  parameter int DW = 12,
  parameter int TW = 12
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2*DW-1:0] A,
  input  logic [2*DW-1:0] B,
  input  logic [2*TW-1:0] Wt,
  input  logic            bypass,
  input  logic            scale,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*DW-1:0] C1,
  output logic [2*DW-1:0] C2,
  output logic            ovf,
  input  logic            ovf_clr
);

  localparam int PW = DW + TW;
  localparam int SW = PW + 1;
  localparam int RW = DW + 2;
  localparam int XW = DW + 3;

  localparam logic signed [SW-1:0] RND  = SW'(2 ** (TW - 2));
  localparam logic signed [XW-1:0] MAXV = XW'(2 ** (DW - 1) - 1);
  localparam logic signed [XW-1:0] MINV = -XW'(2 ** (DW - 1));

  function automatic logic signed [XW-1:0] halve(
    input logic signed [XW-1:0] x,
    input logic                 s
  );
    return s ? ((x + XW'(1)) >>> 1) : x;
  endfunction

  // Returns {clipped, value}
  function automatic logic [DW:0] sat(input logic signed [XW-1:0] x);
    logic [DW:0] r;
    if (x > MAXV)
      r = {1'b1, 1'b0, {(DW-1){1'b1}}};
    else if (x < MINV)
      r = {1'b1, 1'b1, {(DW-1){1'b0}}};
    else
      r = {1'b0, x[DW-1:0]};
    return r;
  endfunction

  logic en;

  // Stage 1
  logic                   v1_q, byp1_q, scl1_q;
  logic [2*DW-1:0]        a1_q, b1_q;
  logic signed [PW-1:0]   br_x, bi_x, wr_x, wi_x;
  logic signed [PW-1:0]   rr_d, ii_d, ri_d, ir_d;
  logic signed [PW-1:0]   rr_q, ii_q, ri_q, ir_q;

  // Stage 2
  logic                   v2_q, scl2_q;
  logic [2*DW-1:0]        a2_q;
  logic signed [SW-1:0]   pr_w, pi_w;
  logic signed [RW-1:0]   pr_d, pi_d, pr_q, pi_q;

  // Stage 3
  logic                   v3_q, ovf_q, ovf_d, clip;
  logic [2*DW-1:0]        c1_d, c2_d, c1_q, c2_q;
  logic signed [XW-1:0]   ar_x, ai_x;
  logic [DW:0]            sr, si, dr, di;

  assign en       = ~v3_q | out_ready;
  assign in_ready = en;

  assign br_x = PW'($signed(B[2*DW-1:DW]));
  assign bi_x = PW'($signed(B[DW-1:0]));
  assign wr_x = PW'($signed(Wt[2*TW-1:TW]));
  assign wi_x = PW'($signed(Wt[TW-1:0]));

  assign rr_d = br_x * wr_x;
  assign ii_d = bi_x * wi_x;
  assign ri_d = br_x * wi_x;
  assign ir_d = bi_x * wr_x;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q   <= 1'b0;
      byp1_q <= 1'b0;
      scl1_q <= 1'b0;
      a1_q   <= '0;
      b1_q   <= '0;
      rr_q   <= '0;
      ii_q   <= '0;
      ri_q   <= '0;
      ir_q   <= '0;
    end else if (en) begin
      v1_q   <= in_valid;
      byp1_q <= bypass;
      scl1_q <= scale;
      a1_q   <= A;
      b1_q   <= B;
      rr_q   <= rr_d;
      ii_q   <= ii_d;
      ri_q   <= ri_d;
      ir_q   <= ir_d;
    end
  end

  assign pr_w = SW'(rr_q) - SW'(ii_q);
  assign pi_w = SW'(ri_q) + SW'(ir_q);

  // Round-half-up back to Q0 before the add/sub stage
  always_comb begin
    if (byp1_q) begin
      pr_d = RW'($signed(b1_q[2*DW-1:DW]));
      pi_d = RW'($signed(b1_q[DW-1:0]));
    end else begin
      pr_d = RW'((pr_w + RND) >>> (TW - 1));
      pi_d = RW'((pi_w + RND) >>> (TW - 1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q   <= 1'b0;
      scl2_q <= 1'b0;
      a2_q   <= '0;
      pr_q   <= '0;
      pi_q   <= '0;
    end else if (en) begin
      v2_q   <= v1_q;
      scl2_q <= scl1_q;
      a2_q   <= a1_q;
      pr_q   <= pr_d;
      pi_q   <= pi_d;
    end
  end

  assign ar_x = XW'($signed(a2_q[2*DW-1:DW]));
  assign ai_x = XW'($signed(a2_q[DW-1:0]));

  always_comb begin
    sr    = sat(halve(ar_x + XW'(pr_q), scl2_q));
    si    = sat(halve(ai_x + XW'(pi_q), scl2_q));
    dr    = sat(halve(ar_x - XW'(pr_q), scl2_q));
    di    = sat(halve(ai_x - XW'(pi_q), scl2_q));
    clip  = sr[DW] | si[DW] | dr[DW] | di[DW];
    c1_d  = {sr[DW-1:0], si[DW-1:0]};
    c2_d  = {dr[DW-1:0], di[DW-1:0]};
    ovf_d = (en & v2_q & clip) | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3_q  <= 1'b0;
      c1_q  <= '0;
      c2_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      if (en) begin
        v3_q <= v2_q;
        c1_q <= c1_d;
        c2_q <= c2_d;
      end
    end
  end

  assign out_valid = v3_q;
  assign C1        = c1_q;
  assign C2        = c2_q;
  assign ovf       = ovf_q;

endmodule
